// File: rtl/fetch_stage_pkg.sv
// Shared constants for the instruction fetch stage: opcodes, bubble word, FSM states.
package fetch_stage_pkg;

  localparam int unsigned ADDR_W = 16;
  localparam int unsigned INSTR_W = 16;

  localparam logic [4:0] OP_HALT = 5'b00000;
  localparam logic [4:0] OP_NOP  = 5'b00001;

  // A bubble carries the NOP opcode so decode treats it as harmless.
  localparam logic [INSTR_W-1:0] NOP_WORD = 16'h0800;

  typedef enum logic {
    ST_RUN    = 1'b0,
    ST_HALTED = 1'b1
  } fetch_state_t;

  function automatic logic [4:0] opcode_of(input logic [INSTR_W-1:0] instr);
    return instr[15:11];
  endfunction

endpackage

// File: rtl/fetch_stage_pc_inc.sv
// Combinational PC+2 incrementer; wraps modulo 2^16 without any carry-out.
module pc_inc
  import fetch_stage_pkg::*;
(
  input  logic [ADDR_W-1:0] pc,
  output logic [ADDR_W-1:0] pc_plus2
);

  assign pc_plus2 = pc + 16'd2;

endmodule

// File: rtl/fetch_stage.sv
// Instruction fetch stage: PC register, IF/ID pipeline register and RUN/HALTED FSM.
module fetch_stage
  import fetch_stage_pkg::*;
#(
  parameter logic [15:0] RESET_PC = 16'h0000
) (
  input  logic        clk,
  input  logic        rst,
  output logic [15:0] imem_addr,
  output logic        imem_rd_en,
  input  logic [15:0] imem_data,
  input  logic        imem_valid,
  input  logic        stall_id,
  input  logic        redirect,
  input  logic [15:0] redirect_pc,
  output logic [15:0] if_id_instr,
  output logic [15:0] if_id_pc2,
  output logic        if_id_valid,
  output logic        halted
);

  fetch_state_t state;
  logic [15:0]  pc;
  logic [15:0]  pc_plus2;

  pc_inc u_pc_inc (
    .pc       (pc),
    .pc_plus2 (pc_plus2)
  );

  assign imem_addr  = pc;
  assign imem_rd_en = (state == ST_RUN) && !rst;

  // PC, IF/ID and FSM update; priority rst > redirect > stall > wait/halted > fetch.
  always_ff @(posedge clk) begin
    if (rst) begin
      pc          <= RESET_PC;
      state       <= ST_RUN;
      halted      <= 1'b0;
      if_id_instr <= NOP_WORD;
      if_id_pc2   <= 16'h0000;
      if_id_valid <= 1'b0;
    end else if (redirect) begin
      // A resolved branch squashes whatever is being fetched, including a HALT.
      pc          <= redirect_pc;
      state       <= ST_RUN;
      halted      <= 1'b0;
      if_id_instr <= NOP_WORD;
      if_id_valid <= 1'b0;
    end else if (stall_id) begin
      // Decode hazard: everything holds.
    end else if (state == ST_HALTED || !imem_valid) begin
      // Nothing fetched this cycle: hand decode a bubble, keep PC.
      if_id_instr <= NOP_WORD;
      if_id_valid <= 1'b0;
    end else begin
      if_id_instr <= imem_data;
      if_id_pc2   <= pc_plus2;
      if_id_valid <= 1'b1;
      if (opcode_of(imem_data) == OP_HALT) begin
        // PC parks on the HALT so a later reset/redirect view is consistent.
        state  <= ST_HALTED;
        halted <= 1'b1;
      end else begin
        pc <= pc_plus2;
      end
    end
  end

endmodule

// File: tb/tb_fetch_stage.sv
// Directed self-checking bench for fetch_stage.
module tb_fetch_stage;

  logic        clk = 1'b0;
  logic        rst;
  logic [15:0] imem_addr;
  logic        imem_rd_en;
  logic [15:0] imem_data;
  logic        imem_valid;
  logic        stall_id;
  logic        redirect;
  logic [15:0] redirect_pc;
  logic [15:0] if_id_instr;
  logic [15:0] if_id_pc2;
  logic        if_id_valid;
  logic        halted;

  int checks = 0;
  int errors = 0;

  fetch_stage #(.RESET_PC(16'h0000)) dut (
    .clk         (clk),
    .rst         (rst),
    .imem_addr   (imem_addr),
    .imem_rd_en  (imem_rd_en),
    .imem_data   (imem_data),
    .imem_valid  (imem_valid),
    .stall_id    (stall_id),
    .redirect    (redirect),
    .redirect_pc (redirect_pc),
    .if_id_instr (if_id_instr),
    .if_id_pc2   (if_id_pc2),
    .if_id_valid (if_id_valid),
    .halted      (halted)
  );

  always #5 clk = ~clk;

  // Advance one clock and settle 1ns past the edge before sampling.
  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic test_reset();
    rst = 1'b1; imem_valid = 1'b0; imem_data = 16'h0000;
    stall_id = 1'b0; redirect = 1'b0; redirect_pc = 16'h0000;
    step(); step();
    checks++; if (imem_addr !== 16'h0000) begin errors++; $display("FAIL rst_addr: got %h want 0000", imem_addr); end
    checks++; if (if_id_instr !== 16'h0800) begin errors++; $display("FAIL rst_instr: got %h want 0800", if_id_instr); end
    checks++; if (if_id_pc2 !== 16'h0000) begin errors++; $display("FAIL rst_pc2: got %h want 0000", if_id_pc2); end
    checks++; if (if_id_valid !== 1'b0) begin errors++; $display("FAIL rst_valid: got %b want 0", if_id_valid); end
    checks++; if (halted !== 1'b0) begin errors++; $display("FAIL rst_halted: got %b want 0", halted); end
    checks++; if (imem_rd_en !== 1'b0) begin errors++; $display("FAIL rst_rd_en: got %b want 0", imem_rd_en); end
    rst = 1'b0;
    #1;
    checks++; if (imem_rd_en !== 1'b1) begin errors++; $display("FAIL run_rd_en: got %b want 1", imem_rd_en); end
  endtask

  task automatic test_fetch();
    imem_valid = 1'b1; imem_data = 16'h4000;
    checks++; if (imem_addr !== 16'h0000) begin errors++; $display("FAIL fetch0_addr: got %h want 0000", imem_addr); end
    step();
    checks++; if (if_id_instr !== 16'h4000) begin errors++; $display("FAIL fetch0_instr: got %h want 4000", if_id_instr); end
    checks++; if (if_id_pc2 !== 16'h0002) begin errors++; $display("FAIL fetch0_pc2: got %h want 0002", if_id_pc2); end
    checks++; if (if_id_valid !== 1'b1) begin errors++; $display("FAIL fetch0_valid: got %b want 1", if_id_valid); end
    checks++; if (imem_addr !== 16'h0002) begin errors++; $display("FAIL fetch1_addr: got %h want 0002", imem_addr); end
    imem_data = 16'h4100;
    step();
    checks++; if (if_id_instr !== 16'h4100) begin errors++; $display("FAIL fetch1_instr: got %h want 4100", if_id_instr); end
    checks++; if (if_id_pc2 !== 16'h0004) begin errors++; $display("FAIL fetch1_pc2: got %h want 0004", if_id_pc2); end
    checks++; if (imem_addr !== 16'h0004) begin errors++; $display("FAIL fetch2_addr: got %h want 0004", imem_addr); end
  endtask

  task automatic test_stall();
    stall_id = 1'b1; imem_data = 16'h4200;
    for (int i = 0; i < 2; i++) begin
      step();
      checks++; if (imem_addr !== 16'h0004) begin errors++; $display("FAIL stall_addr[%0d]: got %h want 0004", i, imem_addr); end
      checks++; if (if_id_instr !== 16'h4100) begin errors++; $display("FAIL stall_instr[%0d]: got %h want 4100", i, if_id_instr); end
      checks++; if (if_id_pc2 !== 16'h0004 || if_id_valid !== 1'b1) begin errors++; $display("FAIL stall_pc2_valid[%0d]: got %h/%b want 0004/1", i, if_id_pc2, if_id_valid); end
    end
    stall_id = 1'b0;
    step();
    checks++; if (if_id_instr !== 16'h4200 || if_id_pc2 !== 16'h0006) begin errors++; $display("FAIL stall_resume: got %h/%h want 4200/0006", if_id_instr, if_id_pc2); end
    checks++; if (imem_addr !== 16'h0006) begin errors++; $display("FAIL stall_resume_addr: got %h want 0006", imem_addr); end
  endtask

  task automatic test_mem_wait();
    imem_valid = 1'b0; imem_data = 16'h4300;
    for (int i = 0; i < 3; i++) begin
      step();
      checks++; if (if_id_instr !== 16'h0800 || if_id_valid !== 1'b0) begin errors++; $display("FAIL wait_bubble[%0d]: got %h/%b want 0800/0", i, if_id_instr, if_id_valid); end
      checks++; if (if_id_pc2 !== 16'h0006) begin errors++; $display("FAIL wait_pc2[%0d]: got %h want 0006", i, if_id_pc2); end
      checks++; if (imem_addr !== 16'h0006) begin errors++; $display("FAIL wait_addr[%0d]: got %h want 0006", i, imem_addr); end
    end
    imem_valid = 1'b1;
    step();
    checks++; if (if_id_instr !== 16'h4300 || if_id_pc2 !== 16'h0008 || if_id_valid !== 1'b1) begin errors++; $display("FAIL wait_resume: got %h/%h/%b want 4300/0008/1", if_id_instr, if_id_pc2, if_id_valid); end
    checks++; if (imem_addr !== 16'h0008) begin errors++; $display("FAIL wait_resume_addr: got %h want 0008", imem_addr); end
  endtask

  task automatic test_halt();
    redirect = 1'b1; redirect_pc = 16'h0010;
    step();
    checks++; if (imem_addr !== 16'h0010 || if_id_valid !== 1'b0 || if_id_instr !== 16'h0800) begin errors++; $display("FAIL redir_0010: got %h/%b/%h want 0010/0/0800", imem_addr, if_id_valid, if_id_instr); end
    redirect = 1'b0; imem_data = 16'h0000; imem_valid = 1'b1;
    step();
    checks++; if (if_id_instr !== 16'h0000 || if_id_valid !== 1'b1) begin errors++; $display("FAIL halt_latch: got %h/%b want 0000/1", if_id_instr, if_id_valid); end
    checks++; if (halted !== 1'b1 || imem_rd_en !== 1'b0) begin errors++; $display("FAIL halt_state: got halted %b rd_en %b want 1/0", halted, imem_rd_en); end
    checks++; if (imem_addr !== 16'h0010) begin errors++; $display("FAIL halt_addr: got %h want 0010", imem_addr); end
    step();
    checks++; if (if_id_instr !== 16'h0800 || if_id_valid !== 1'b0 || imem_addr !== 16'h0010 || halted !== 1'b1) begin errors++; $display("FAIL halted_bubble: got %h/%b/%h/%b want 0800/0/0010/1", if_id_instr, if_id_valid, imem_addr, halted); end
    redirect = 1'b1; redirect_pc = 16'h0040;
    step();
    redirect = 1'b0;
    checks++; if (imem_addr !== 16'h0040 || halted !== 1'b0 || imem_rd_en !== 1'b1) begin errors++; $display("FAIL halt_exit: got %h/%b/%b want 0040/0/1", imem_addr, halted, imem_rd_en); end
  endtask

  task automatic test_redirect_priority();
    stall_id = 1'b1; imem_valid = 1'b0; redirect = 1'b1; redirect_pc = 16'h0100;
    step();
    checks++; if (imem_addr !== 16'h0100 || if_id_instr !== 16'h0800 || if_id_valid !== 1'b0) begin errors++; $display("FAIL redir_prio: got %h/%h/%b want 0100/0800/0", imem_addr, if_id_instr, if_id_valid); end
    redirect_pc = 16'hFFFE;
    step();
    redirect = 1'b0; stall_id = 1'b0; imem_valid = 1'b1; imem_data = 16'h4400;
    step();
    checks++; if (if_id_pc2 !== 16'h0000 || if_id_instr !== 16'h4400) begin errors++; $display("FAIL wrap_pc2: got %h/%h want 0000/4400", if_id_pc2, if_id_instr); end
    checks++; if (imem_addr !== 16'h0000) begin errors++; $display("FAIL wrap_addr: got %h want 0000", imem_addr); end
  endtask

  task automatic test_redirect_vs_halt();
    imem_valid = 1'b1; imem_data = 16'h0000; redirect = 1'b1; redirect_pc = 16'h0020;
    step();
    redirect = 1'b0; imem_valid = 1'b0;
    checks++; if (halted !== 1'b0 || imem_addr !== 16'h0020 || if_id_valid !== 1'b0 || imem_rd_en !== 1'b1) begin errors++; $display("FAIL redir_halt: got %b/%h/%b/%b want 0/0020/0/1", halted, imem_addr, if_id_valid, imem_rd_en); end
  endtask

  task automatic test_reset_halted();
    imem_valid = 1'b1; imem_data = 16'h0000;
    step();
    checks++; if (halted !== 1'b1) begin errors++; $display("FAIL pre_rst_halted: got %b want 1", halted); end
    stall_id = 1'b1; rst = 1'b1;
    step();
    checks++; if (imem_addr !== 16'h0000 || if_id_instr !== 16'h0800 || if_id_pc2 !== 16'h0000) begin errors++; $display("FAIL rst_halt_regs: got %h/%h/%h want 0000/0800/0000", imem_addr, if_id_instr, if_id_pc2); end
    checks++; if (if_id_valid !== 1'b0 || halted !== 1'b0 || imem_rd_en !== 1'b0) begin errors++; $display("FAIL rst_halt_flags: got %b/%b/%b want 0/0/0", if_id_valid, halted, imem_rd_en); end
    rst = 1'b0; stall_id = 1'b0; imem_data = 16'h4500;
    step();
    checks++; if (if_id_instr !== 16'h4500 || if_id_pc2 !== 16'h0002 || imem_addr !== 16'h0002) begin errors++; $display("FAIL post_rst_fetch: got %h/%h/%h want 4500/0002/0002", if_id_instr, if_id_pc2, imem_addr); end
  endtask

  initial begin
    test_reset();
    test_fetch();
    test_stall();
    test_mem_wait();
    test_halt();
    test_redirect_priority();
    test_redirect_vs_halt();
    test_reset_halted();
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule

// File: doc/fetch_stage.md
FETCH_STAGE -- requirements
Module: fetch_stage

Interface
REQ-001 Parameter: RESET_PC, 16'h0000, PC value loaded on reset.
REQ-002 Port: clk  input  1  single clock; all state updates on rising edge.
REQ-003 Port: rst  input  1  reset, synchronous and active-high.
REQ-004 Port: imem_addr  output  16  instruction memory address; combinational copy of PC.
REQ-005 Port: imem_rd_en  output  1  read request; high only in state RUN and rst low.
REQ-006 Port: imem_data  input  16  instruction word for imem_addr, same cycle.
REQ-007 Port: imem_valid  input  1  imem_data usable this cycle; low = memory stall.
REQ-008 Port: stall_id  input  1  decode hazard; freeze PC and IF/ID.
REQ-009 Port: redirect  input  1  taken branch/jump resolved downstream.
REQ-010 Port: redirect_pc  input  16  target PC, used when redirect high.
REQ-011 Port: if_id_instr  output  16  registered instruction to decode; bits [15:11] are the opcode consumed by the sign-extend select decoder.
REQ-012 Port: if_id_pc2  output  16  registered PC+2 of if_id_instr.
REQ-013 Port: if_id_valid  output  1  if_id_instr is a real fetched instruction, not a bubble.
REQ-014 Port: halted  output  1  registered; high while state is HALTED.

Function
REQ-015 States: RUN, HALTED; two-state FSM.
REQ-016 Per-cycle priority: rst > redirect > stall_id > (state HALTED or imem_valid low) > normal fetch.
REQ-017 Redirect: PC <= redirect_pc; IF/ID <= bubble; state <= RUN; stall_id and imem_valid ignored that cycle.
REQ-018 Stall (no redirect): PC, if_id_instr, if_id_pc2, if_id_valid, state all hold.
REQ-019 Memory wait (RUN, imem_valid low, no stall/redirect): PC holds; IF/ID <= bubble.
REQ-020 Normal fetch (RUN, imem_valid high): if_id_instr <= imem_data; if_id_pc2 <= PC+2; if_id_valid <= 1; PC <= PC+2.
REQ-021 PC+2 is 16-bit modulo; 16'hFFFE increments to 16'h0000 with no flag.
REQ-022 Bubble = if_id_instr 16'h0800 (NOP opcode 5'b00001), if_id_pc2 unchanged, if_id_valid 0.
REQ-023 HALT detect: normal fetch with imem_data[15:11] == 5'b00000 latches HALT into IF/ID (valid 1), PC does not increment, state <= HALTED.
REQ-024 HALTED: imem_rd_en 0; PC holds; IF/ID <= bubble each cycle unless stall_id (hold).
REQ-025 HALTED exits only via redirect (older branch squashes HALT) -> RUN at redirect_pc.
REQ-026 Redirect coincident with fetched HALT: redirect wins; HALT discarded; state RUN.
REQ-027 Latency: instruction at PC appears on if_id_instr one cycle after imem_valid high.

Reset
REQ-028 On rst high at clock edge: PC <= RESET_PC, state <= RUN, if_id_instr <= 16'h0800, if_id_pc2 <= 16'h0000, if_id_valid <= 0, halted <= 0.
REQ-029 rst mid-stall, mid-wait or in HALTED overrides all inputs; first fetch from RESET_PC on the cycle after rst falls.

Structure
REQ-030 Shared package holds: opcode constants OP_HALT 5'b00000, OP_NOP 5'b00001, NOP word 16'h0800, FSM state encoding.
REQ-031 One sub-module: pc_inc (16-bit +2 incrementer, combinational), instantiated once.

Verification
REQ-032 Reset, imem returns 16'h4000,16'h4100 with imem_valid 1 -> imem_addr 0x0000,0x0002; if_id_instr 16'h4000 then 16'h4100; if_id_pc2 0x0002 then 0x0004; valid 1.
REQ-033 stall_id high 2 cycles at PC 0x0004 -> imem_addr stays 0x0004, IF/ID unchanged; resumes with next word after release.
REQ-034 imem_valid low 3 cycles -> three bubbles (16'h0800, valid 0), PC held; fetch resumes at same address.
REQ-035 Fetch 16'h0000 at 0x0010 -> if_id_instr 16'h0000 valid 1, halted 1 next cycle, imem_rd_en 0, PC stays 0x0010; redirect to 0x0040 -> RUN, imem_addr 0x0040, halted 0.
REQ-036 redirect with stall_id and imem_valid low same cycle, target 0x0100 -> PC 0x0100, bubble; PC 0xFFFE normal fetch -> if_id_pc2 0x0000, PC 0x0000.
REQ-037 rst asserted while HALTED with stall_id high -> all outputs at REQ-028 values, imem_addr RESET_PC.
